// File: rtl/dpb_pkg.sv
// Shared defaults and types for the gowin_dpb dual-port block RAM.
package dpb_pkg;

    localparam int DEF_ADDR_W = 11;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 1 << DEF_ADDR_W;

    typedef logic [DEF_ADDR_W-1:0] addr_t;
    typedef logic [DEF_DATA_W-1:0] data_t;

endpackage

// File: rtl/gowin_dpb_if.sv
// Port bundle for both RAM ports. The user side drives controls and data,
// the RAM side returns the registered read data.
interface gowin_dpb_if
    import dpb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              cea;
    logic              ceb;
    logic              ocea;
    logic              oceb;
    logic              wrea;
    logic              wreb;
    logic [ADDR_W-1:0] ada;
    logic [ADDR_W-1:0] adb;
    logic [DATA_W-1:0] dina;
    logic [DATA_W-1:0] dinb;
    logic [DATA_W-1:0] douta;
    logic [DATA_W-1:0] doutb;

    modport master (
        output cea, ceb, ocea, oceb, wrea, wreb, ada, adb, dina, dinb,
        input  douta, doutb
    );

    modport slave (
        input  cea, ceb, ocea, oceb, wrea, wreb, ada, adb, dina, dinb,
        output douta, doutb
    );

endinterface

// File: rtl/dpb_out_pipe.sv
// Two-stage read pipeline for one RAM port: stage 1 captures the array word
// on read cycles, stage 2 is the output register gated by oce.
module dpb_out_pipe
    import dpb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic              wre,
    input  logic              oce,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] stage1;

    // Stage 1: capture the addressed word only on enabled read cycles;
    // writes leave it untouched (normal write mode).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage1 <= '0;
        end else if (ce && !wre) begin
            stage1 <= rd_data;
        end
    end

    // Stage 2: output register, independent of ce.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
        end else if (oce) begin
            dout <= stage1;
        end
    end

endmodule

// File: rtl/gowin_dpb.sv
// True dual-port RAM, 2^ADDR_W x DATA_W, single clock. Reads are
// read-before-write against either port; on a same-address double write
// port B wins. The array is never cleared by rst_n.
module gowin_dpb
    import dpb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic        clk,
    input  logic        rst_n,
    gowin_dpb_if.slave  bus
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    // Asynchronous array read; stage 1 samples it at the edge, so a
    // concurrent write lands after the old word has been captured.
    always_comb begin
        rd_a = mem[bus.ada];
        rd_b = mem[bus.adb];
    end

    // Array writes. Port B is applied last so it wins a same-address
    // collision; no writes while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (bus.cea && bus.wrea) begin
                mem[bus.ada] <= bus.dina;
            end
            if (bus.ceb && bus.wreb) begin
                mem[bus.adb] <= bus.dinb;
            end
        end
    end

    dpb_out_pipe #(.DATA_W(DATA_W)) u_pipe_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .ce      (bus.cea),
        .wre     (bus.wrea),
        .oce     (bus.ocea),
        .rd_data (rd_a),
        .dout    (bus.douta)
    );

    dpb_out_pipe #(.DATA_W(DATA_W)) u_pipe_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .ce      (bus.ceb),
        .wre     (bus.wreb),
        .oce     (bus.oceb),
        .rd_data (rd_b),
        .dout    (bus.doutb)
    );

endmodule

// File: tb/tb_gowin_dpb.sv
// Scoreboard bench for gowin_dpb: a plain-array memory model queues the
// expected word of every read; a monitor pops and compares when the read
// result is due at the port output.
module tb_gowin_dpb;
    import dpb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gowin_dpb_if bus ();

    gowin_dpb dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    data_t mm [DEF_DEPTH];
    data_t q_a [$];
    data_t q_b [$];
    bit    pend_a = 0, pend_b = 0, rdy_a = 0, rdy_b = 0;
    bit    sb_on  = 1;

    task automatic chk(input string nm, input data_t act, input data_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h want %02h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: reads see the array before this edge's writes,
    // B's write is applied after A's, and a read result appears one edge later.
    always @(posedge clk) begin
        if (!rst_n) begin
            pend_a = 0; pend_b = 0; rdy_a = 0; rdy_b = 0;
            q_a.delete(); q_b.delete();
        end else begin
            rdy_a  = pend_a;
            rdy_b  = pend_b;
            pend_a = sb_on && bus.cea && !bus.wrea;
            pend_b = sb_on && bus.ceb && !bus.wreb;
            if (pend_a) q_a.push_back(mm[bus.ada]);
            if (pend_b) q_b.push_back(mm[bus.adb]);
            if (bus.cea && bus.wrea) mm[bus.ada] = bus.dina;
            if (bus.ceb && bus.wreb) mm[bus.adb] = bus.dinb;
        end
    end

    // Monitor: compare whenever a read result is due on a port.
    always begin
        @(posedge clk);
        #1;
        if (rdy_a) begin
            if (q_a.size() == 0) begin
                total++; bad++;
                $display("FAIL sb_a_underflow: got empty queue want entry");
            end else chk("sb_douta", bus.douta, q_a.pop_front());
        end
        if (rdy_b) begin
            if (q_b.size() == 0) begin
                total++; bad++;
                $display("FAIL sb_b_underflow: got empty queue want entry");
            end else chk("sb_doutb", bus.doutb, q_b.pop_front());
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic drive_a(input bit ce, input bit we, input int ad, input data_t d);
        bus.cea = ce; bus.wrea = we; bus.ada = addr_t'(ad); bus.dina = d;
    endtask

    task automatic drive_b(input bit ce, input bit we, input int ad, input data_t d);
        bus.ceb = ce; bus.wreb = we; bus.adb = addr_t'(ad); bus.dinb = d;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        drive_a(0, 0, 0, 8'h00);
        drive_b(0, 0, 0, 8'h00);
        repeat (n) step();
    endtask

    initial begin
        foreach (mm[i]) mm[i] = '0;
        bus.ocea = 1'b1;
        bus.oceb = 1'b1;
        drive_a(0, 0, 0, 8'h00);
        drive_b(0, 0, 0, 8'h00);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_douta", bus.douta, 8'h00);
        chk("reset_doutb", bus.doutb, 8'h00);
        rst_n = 1'b1;

        // Traffic before a mid-stream reset: douta ends up holding 0x77.
        drive_a(1, 1, 10, 8'h77); drive_b(1, 0, 9, 8'h00); step();
        drive_a(1, 0, 10, 8'h00); drive_b(1, 1, 9, 8'h3C); step();
        drive_b(1, 0, 9, 8'h00); drive_a(0, 0, 0, 8'h00); step();
        idle(3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_clr_douta", bus.douta, 8'h00);
        chk("async_clr_doutb", bus.doutb, 8'h00);
        @(negedge clk);
        step();
        chk("rst_hold_douta", bus.douta, 8'h00);
        rst_n = 1'b1;

        // Array survives reset; address 0 was never written.
        drive_a(1, 0, 0, 8'h00); step();
        drive_a(1, 0, 10, 8'h00); step();
        idle(3);

        // Port A writes with step 3, then reads back.
        drive_a(1, 1, 3, 8'hA5); step();
        drive_a(1, 1, 6, 8'h5A); step();
        drive_a(1, 0, 3, 8'h00); step();
        drive_a(1, 0, 6, 8'h00); step();
        idle(3);

        // Output-register hold.
        sb_on = 0;
        drive_a(1, 0, 3, 8'h00); step();
        drive_a(1, 0, 6, 8'h00); step();
        chk("oce_pre", bus.douta, 8'hA5);
        drive_a(0, 0, 0, 8'h00); bus.ocea = 1'b0; step();
        chk("oce_hold1", bus.douta, 8'hA5);
        step();
        chk("oce_hold2", bus.douta, 8'hA5);
        bus.ocea = 1'b1; step();
        chk("oce_resume", bus.douta, 8'h5A);
        idle(2);
        sb_on = 1;

        // Cross-port read-before-write, then re-read.
        drive_a(1, 1, 100, 8'h11); drive_b(1, 0, 100, 8'h00); step();
        drive_a(0, 0, 0, 8'h00);   drive_b(1, 0, 100, 8'h00); step();
        idle(3);

        // Same-address write collision: B wins.
        drive_a(1, 1, 2047, 8'h22); drive_b(1, 1, 2047, 8'h33); step();
        drive_b(0, 0, 0, 8'h00);    drive_a(1, 0, 2047, 8'h00); step();
        idle(3);
        chk("collide_b_wins", bus.douta, 8'h33);

        // ce gating on port B.
        drive_b(1, 0, 100, 8'h00); step();
        idle(3);
        drive_b(0, 1, 5, 8'hFF); step(); step();
        chk("ce_hold_doutb", bus.doutb, 8'h11);
        drive_b(1, 0, 5, 8'h00); step();
        idle(3);
        chk("ce_no_write", bus.doutb, 8'h00);

        // Randomised traffic on a small window plus the top of the array.
        for (int n = 0; n < 400; n++) begin
            int aa, ab;
            aa = ($urandom_range(0, 7) == 0) ? $urandom_range(2040, 2047) : $urandom_range(0, 15);
            ab = ($urandom_range(0, 7) == 0) ? $urandom_range(2040, 2047) : $urandom_range(0, 15);
            drive_a($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, aa, data_t'($urandom));
            drive_b($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, ab, data_t'($urandom));
            step();
        end
        idle(4);

        total++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d/%0d pending want 0/0", q_a.size(), q_b.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gowin_dpb.md
# gowin_dpb

Synchronous true dual-port block RAM, 2048 words × 8 bits, with two independent read/write ports (A and B) sharing one clock. Each port has a clock enable, write enable and a registered (pipelined) output stage with its own output-clock enable. It is the on-chip storage primitive for list and buffer logic, e.g. linked-list engines that walk memory with a fixed address step.

## Interface
- `ADDR_W`, default 11: address width; depth = 2^ADDR_W.
- `DATA_W`, default 8: word width.

Ports:
- `clk`: input, 1, single clock for both ports; rising edge.
- `rst_n`: input, 1, asynchronous, active-low; clears the output pipeline of both ports.
- `cea`, `ceb`: input, 1, port clock enable; 0 means no array access that cycle.
- `ocea`, `oceb`: input, 1, output-register enable.
- `wrea`, `wreb`: input, 1, 1 = write, 0 = read (qualified by ce).
- `ada`, `adb`: input, ADDR_W, word address.
- `dina`, `dinb`: input, DATA_W, write data.
- `douta`, `doutb`: output, DATA_W, registered read data.

## Operation
- Array: 2^ADDR_W × DATA_W. Initialised to all zeros at configuration/simulation start. Never cleared by `rst_n`.
- Per port, every rising `clk` edge with ce=1:
  - wre=1: `mem[ad] <= din`. The port's read stage-1 register is not updated (normal write mode).
  - wre=0: read stage-1 register `<= mem[ad]`.
- ce=0: no array access; stage-1 holds.
- Stage 2 (output register): `dout <= stage1` on edges with oce=1; holds when oce=0. oce is independent of ce.
- Port read vs other-port write, same address, same edge: read returns the old contents (read-before-write).
- Both ports write the same address on the same edge: port B data is stored.
- Same-port read of a just-written address on the next edge returns the new data.
- `rst_n`=0: stage-1 and `dout` of both ports go to 0 immediately (asynchronous) and stay 0 while asserted. Array writes are suppressed while `rst_n`=0.

## Timing
- Read latency is 2 edges. Address presented before edge N (ce=1, wre=0) is captured into stage 1 at N. With oce=1 at N+1, `douta`/`doutb` is valid after N+1.
- Back-to-back reads at one address per cycle give one result per cycle, pipelined 2 deep.
- Write takes effect at the capturing edge. A read issued on the following edge sees it.
- Reset values: `douta` = `doutb` = 0.
- Release of `rst_n` is synchronised by the user. The first edge after release behaves normally.
- Address wrap: none internal. Addresses are taken modulo 2^ADDR_W by width.

## Structure
- Shared package `dpb_pkg`: `ADDR_W`/`DATA_W` defaults and the `addr_t`/`data_t` typedefs.
- Sub-module `dpb_out_pipe`: stage-1 and stage-2 registers with ce/wre/oce gating and async clear. It is instantiated once per port.
- Top module: holds the array, the write arbitration (B wins) and the read-before-write ordering.

## Test plan
- Reset: assert `rst_n`=0 mid-stream → `douta`=`doutb`=0 immediately. Release, then read address 0 → 0x00 (array was never written).
- Port A writes: 0xA5 to address 3, then 0x5A to address 6 (step 3). Read address 3, then address 6, with ocea=1 → `douta` = 0xA5 two edges after the first read, 0x5A one edge later.
- oce hold: read address 3 (0xA5), then read address 6 with ocea=0 → `douta` stays 0xA5. Raise ocea → 0x5A.
- Cross-port: A writes 0x11 to address 100. Same edge, B reads address 100 (old value 0x00) → `doutb`=0x00. B re-reads next cycle → 0x11.
- Write collision: A writes 0x22 and B writes 0x33 to address 2047 on the same edge → read of 2047 returns 0x33.
- ce gating: ceb=0 with wreb=1, `dinb`=0xFF, address 5 → address 5 unchanged, and `doutb` pipeline holds its value.
